// File: rtl/cpu7_ifu_fbuf_if.sv
// cpu7_ifu_fbuf_if -- fetch-group and issue-slot bundle for the IFU fetch buffer.
//
// Handshake: a fetch group (in_pc, in_count, in_rdata, in_ex, in_exccode) is
// transferred on a rising clock edge when in_valid and in_ready are both high
// and the buffer is not being flushed. The producer must hold the group stable
// while in_valid is high and the transfer has not happened. in_ready depends
// only on buffer occupancy, never on in_valid, out_pop or flush.
// On the issue side out_valid is a thermometer mask of presented slots; the
// consumer reports via out_pop how many of the oldest slots it took this cycle
// (values larger than the number of valid slots are clamped by the buffer).
//
// master: fetch producer + decode consumer (drives in_* and out_pop)
// slave : the fetch buffer (drives in_ready and out_*)
interface cpu7_ifu_fbuf_if #(
  parameter int FETCH_W = 4,
  parameter int ISSUE_W = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [31:0]                  in_pc;
  logic [$clog2(FETCH_W)-1:0]   in_count;
  logic [32*FETCH_W-1:0]        in_rdata;
  logic                         in_ex;
  logic [5:0]                   in_exccode;
  logic [ISSUE_W-1:0]           out_valid;
  logic [32*ISSUE_W-1:0]        out_inst;
  logic [32*ISSUE_W-1:0]        out_pc;
  logic [ISSUE_W-1:0]           out_ex;
  logic [6*ISSUE_W-1:0]         out_exccode;
  logic [$clog2(ISSUE_W+1)-1:0] out_pop;

  modport master (
    output in_valid, in_pc, in_count, in_rdata, in_ex, in_exccode, out_pop,
    input  in_ready, out_valid, out_inst, out_pc, out_ex, out_exccode
  );

  modport slave (
    input  in_valid, in_pc, in_count, in_rdata, in_ex, in_exccode, out_pop,
    output in_ready, out_valid, out_inst, out_pc, out_ex, out_exccode
  );
endinterface

// File: rtl/cpu7_ifu_fbuf.sv
// cpu7_ifu_fbuf -- instruction fetch buffer between the fetch unit and decode.
// Fetch groups of up to FETCH_W instructions are split into per-instruction
// entries in a DEPTH-entry circular buffer; the ISSUE_W oldest entries are
// presented combinationally to decode each cycle.
//
// Ports:
//   clock     : single clock, rising edge
//   reset     : asynchronous active-high reset, clears pointers and storage
//   flush     : branch cancel, empties the buffer and drops the offered group
//   bus       : fetch-group input and issue-slot output (slave side)
//   occupancy : current number of buffered entries
module cpu7_ifu_fbuf #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 4,
  parameter int ISSUE_W = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  cpu7_ifu_fbuf_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(FETCH_W+1);

  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  logic        mem_ex   [DEPTH];
  logic [5:0]  mem_exc  [DEPTH];

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;

  logic          ready;
  logic          push;
  logic [NW-1:0] n_push;
  logic [CW-1:0] n_add;
  logic [CW-1:0] p_pop;

  logic [PW-1:0] wr_idx  [FETCH_W];
  logic [31:0]   wr_inst [FETCH_W];
  logic [31:0]   wr_pc   [FETCH_W];
  logic          wr_en   [FETCH_W];

  logic [PW-1:0]          rd_idx;
  logic [ISSUE_W-1:0]     o_valid;
  logic [32*ISSUE_W-1:0]  o_inst;
  logic [32*ISSUE_W-1:0]  o_pc;
  logic [ISSUE_W-1:0]     o_ex;
  logic [6*ISSUE_W-1:0]   o_exc;

  // Accept only when a worst-case full group fits, regardless of in_count.
  assign ready = (count <= CW'(DEPTH - FETCH_W));

  always_comb begin
    // An exception group occupies a single entry; in_count is meaningless then.
    n_push = bus.in_ex ? NW'(1) : (NW'(bus.in_count) + NW'(1));
    push   = bus.in_valid & ready & ~flush;
    n_add  = push ? CW'(n_push) : '0;
    p_pop  = (CW'(bus.out_pop) > count) ? count : CW'(bus.out_pop);
    for (int i = 0; i < FETCH_W; i++) begin
      wr_idx[i]  = wptr + PW'(i);
      wr_en[i]   = push && (NW'(i) < n_push);
      wr_inst[i] = bus.in_ex ? 32'd0 : bus.in_rdata[32*i +: 32];
      wr_pc[i]   = bus.in_pc + 32'(4*i);
    end
  end

  always_comb begin
    rd_idx  = '0;
    o_valid = '0;
    o_inst  = '0;
    o_pc    = '0;
    o_ex    = '0;
    o_exc   = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      rd_idx            = rptr + PW'(i);
      o_valid[i]        = (count > CW'(i));
      o_inst[32*i +: 32] = mem_inst[rd_idx];
      o_pc[32*i +: 32]   = mem_pc[rd_idx];
      o_ex[i]           = mem_ex[rd_idx];
      o_exc[6*i +: 6]   = mem_exc[rd_idx];
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = o_valid;
  assign bus.out_inst    = o_inst;
  assign bus.out_pc      = o_pc;
  assign bus.out_ex      = o_ex;
  assign bus.out_exccode = o_exc;
  assign occupancy       = count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        mem_inst[e] <= '0;
        mem_pc[e]   <= '0;
        mem_ex[e]   <= 1'b0;
        mem_exc[e]  <= '0;
      end
    end else if (flush) begin
      // Storage contents are left stale; count=0 hides them.
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (wr_en[i]) begin
          mem_inst[wr_idx[i]] <= wr_inst[i];
          mem_pc[wr_idx[i]]   <= wr_pc[i];
          mem_ex[wr_idx[i]]   <= bus.in_ex;
          mem_exc[wr_idx[i]]  <= bus.in_ex ? bus.in_exccode : 6'd0;
        end
      end
      wptr  <= wptr + PW'(n_add);
      rptr  <= rptr + PW'(p_pop);
      count <= count + n_add - p_pop;
    end
  end
endmodule

// File: tb/tb_cpu7_ifu_fbuf.sv
// Directed bench for cpu7_ifu_fbuf with DEPTH=8, FETCH_W=4, ISSUE_W=2.
module tb_cpu7_ifu_fbuf;
  logic       clock;
  logic       reset;
  logic       flush;
  logic [3:0] occupancy;
  int         checks;
  int         failures;

  cpu7_ifu_fbuf_if #(.FETCH_W(4), .ISSUE_W(2)) fb_if ();

  cpu7_ifu_fbuf #(.DEPTH(8), .FETCH_W(4), .ISSUE_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (fb_if.slave),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic offer(input logic [31:0] pc, input logic [1:0] cnt,
                       input logic [127:0] data, input logic ex, input logic [5:0] exc);
    fb_if.in_valid   = 1'b1;
    fb_if.in_pc      = pc;
    fb_if.in_count   = cnt;
    fb_if.in_rdata   = data;
    fb_if.in_ex      = ex;
    fb_if.in_exccode = exc;
  endtask

  task automatic idle();
    fb_if.in_valid = 1'b0;
    fb_if.in_ex    = 1'b0;
    fb_if.out_pop  = 2'd0;
  endtask

  task automatic chk_slot(input string tag, input int s, input logic [31:0] inst,
                          input logic [31:0] pc);
    chk({tag, "_inst"}, {32'd0, fb_if.out_inst[32*s +: 32]}, {32'd0, inst});
    chk({tag, "_pc"},   {32'd0, fb_if.out_pc[32*s +: 32]},   {32'd0, pc});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    fb_if.in_valid   = 1'b0;
    fb_if.in_pc      = '0;
    fb_if.in_count   = '0;
    fb_if.in_rdata   = '0;
    fb_if.in_ex      = 1'b0;
    fb_if.in_exccode = '0;
    fb_if.out_pop    = '0;
    #12;
    chk("rst_occ",   64'(occupancy), 64'd0);
    chk("rst_valid", 64'(fb_if.out_valid), 64'd0);
    chk("rst_ready", 64'(fb_if.in_ready), 64'd1);
    chk("rst_inst",  64'(fb_if.out_inst), 64'd0);
    reset = 1'b0;
    step();

    // basic push of a full group
    offer(32'h1C00_0000, 2'd3, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1'b0, 6'd0);
    step();
    idle();
    chk("p1_occ",   64'(occupancy), 64'd4);
    chk("p1_valid", 64'(fb_if.out_valid), 64'd3);
    chk_slot("p1_s0", 0, 32'hAAAA_0001, 32'h1C00_0000);
    chk_slot("p1_s1", 1, 32'hBBBB_0002, 32'h1C00_0004);
    chk("p1_ex",    64'(fb_if.out_ex), 64'd0);
    chk("p1_ready", 64'(fb_if.in_ready), 64'd1);

    fb_if.out_pop = 2'd2;
    step();
    idle();
    chk("pop1_occ", 64'(occupancy), 64'd2);
    chk_slot("pop1_s0", 0, 32'hCCCC_0003, 32'h1C00_0008);
    chk_slot("pop1_s1", 1, 32'hDDDD_0004, 32'h1C00_000C);

    // out_pop above count is clamped
    fb_if.out_pop = 2'd3;
    step();
    chk("clamp_occ",   64'(occupancy), 64'd0);
    chk("clamp_valid", 64'(fb_if.out_valid), 64'd0);
    fb_if.out_pop = 2'd2;
    step();
    idle();
    chk("empty_pop_occ", 64'(occupancy), 64'd0);

    // fill to full, third group held off (rptr=wptr=4 here)
    offer(32'h0000_0100, 2'd3, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1'b0, 6'd0);
    step();
    offer(32'h0000_0200, 2'd3, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1'b0, 6'd0);
    step();
    chk("full_occ",   64'(occupancy), 64'd8);
    chk("full_ready", 64'(fb_if.in_ready), 64'd0);
    offer(32'h0000_0300, 2'd3, {32'h13, 32'h12, 32'h11, 32'h10}, 1'b0, 6'd0);
    step();
    chk("held_occ", 64'(occupancy), 64'd8);
    fb_if.out_pop = 2'd2;
    step();
    chk("full6_occ",   64'(occupancy), 64'd6);
    chk("full6_ready", 64'(fb_if.in_ready), 64'd0);
    chk_slot("full6_s0", 0, 32'hE2, 32'h0000_0108);
    step();
    chk("full4_occ",   64'(occupancy), 64'd4);
    chk("full4_ready", 64'(fb_if.in_ready), 64'd1);
    chk_slot("full4_s0", 0, 32'hF0, 32'h0000_0200);
    // simultaneous push of held group and pop of 2
    step();
    idle();
    chk("pushpop_occ", 64'(occupancy), 64'd6);
    chk_slot("pushpop_s0", 0, 32'hF2, 32'h0000_0208);
    chk_slot("pushpop_s1", 1, 32'hF3, 32'h0000_020C);
    fb_if.out_pop = 2'd2;
    step();
    chk_slot("held_s0", 0, 32'h10, 32'h0000_0300);
    chk_slot("held_s1", 1, 32'h11, 32'h0000_0304);
    step();
    step();
    idle();
    chk("drain_occ", 64'(occupancy), 64'd0);

    // wrap: rptr=wptr=0; fill 8, pop 6, push 4 at wptr=0 with rptr=6
    offer(32'h0000_0400, 2'd3, {32'h43, 32'h42, 32'h41, 32'h40}, 1'b0, 6'd0);
    step();
    offer(32'h0000_0410, 2'd3, {32'h47, 32'h46, 32'h45, 32'h44}, 1'b0, 6'd0);
    step();
    idle();
    fb_if.out_pop = 2'd2;
    step();
    step();
    step();
    chk("wrap_occ2", 64'(occupancy), 64'd2);
    fb_if.out_pop = 2'd0;
    offer(32'h0000_0420, 2'd3, {32'h4B, 32'h4A, 32'h49, 32'h48}, 1'b0, 6'd0);
    step();
    idle();
    chk("wrap_occ6", 64'(occupancy), 64'd6);
    chk_slot("wrap_s0", 0, 32'h46, 32'h0000_0418);
    chk_slot("wrap_s1", 1, 32'h47, 32'h0000_041C);
    fb_if.out_pop = 2'd2;
    step();
    chk_slot("wrap2_s0", 0, 32'h48, 32'h0000_0420);
    chk_slot("wrap2_s1", 1, 32'h49, 32'h0000_0424);
    step();
    step();
    idle();
    chk("wrap_drain", 64'(occupancy), 64'd0);

    // exception group takes one entry
    offer(32'h0000_0500, 2'd3, {32'h53, 32'h52, 32'h51, 32'h50}, 1'b1, 6'h08);
    step();
    offer(32'h0000_0600, 2'd0, {32'h0, 32'h0, 32'h0, 32'h1234_5678}, 1'b0, 6'h3F);
    step();
    idle();
    chk("ex_occ",   64'(occupancy), 64'd2);
    chk("ex_valid", 64'(fb_if.out_valid), 64'd3);
    chk("ex_ex",    64'(fb_if.out_ex), 64'd1);
    chk("ex_code",  64'(fb_if.out_exccode), 64'h008);
    chk_slot("ex_s0", 0, 32'h0, 32'h0000_0500);
    chk_slot("ex_s1", 1, 32'h1234_5678, 32'h0000_0600);

    // flush at occupancy 5 with a group offered and a pop requested
    offer(32'h0000_0700, 2'd2, {32'h73, 32'h72, 32'h71, 32'h70}, 1'b0, 6'd0);
    step();
    chk("pre_flush_occ", 64'(occupancy), 64'd5);
    offer(32'h0000_0800, 2'd3, {32'h83, 32'h82, 32'h81, 32'h80}, 1'b0, 6'd0);
    fb_if.out_pop = 2'd2;
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_valid", 64'(fb_if.out_valid), 64'd0);
    chk("flush_ready", 64'(fb_if.in_ready), 64'd1);
    offer(32'h0000_0900, 2'd1, {32'h0, 32'h0, 32'h91, 32'h90}, 1'b0, 6'd0);
    step();
    offer(32'h0000_0A00, 2'd0, {32'h0, 32'h0, 32'h0, 32'hA0}, 1'b0, 6'd0);
    step();
    idle();
    chk("post_flush_occ", 64'(occupancy), 64'd3);
    chk_slot("post_flush_s0", 0, 32'h90, 32'h0000_0900);

    // asynchronous reset between edges, group offered during reset
    #2;
    offer(32'h0000_0B00, 2'd3, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 1'b0, 6'd0);
    reset = 1'b1;
    #1;
    chk("arst_occ",   64'(occupancy), 64'd0);
    chk("arst_valid", 64'(fb_if.out_valid), 64'd0);
    chk("arst_inst",  64'(fb_if.out_inst), 64'd0);
    chk("arst_pc",    64'(fb_if.out_pc), 64'd0);
    chk("arst_ready", 64'(fb_if.in_ready), 64'd1);
    step();
    chk("arst_hold_occ", 64'(occupancy), 64'd0);
    #2;
    reset = 1'b0;
    step();
    idle();
    chk("resume_occ", 64'(occupancy), 64'd4);
    chk_slot("resume_s0", 0, 32'hB0, 32'h0000_0B00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
